// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit 7-segment scanner.
//   NUM_DIGITS   : number of multiplexed digits on the board
//   nibble_t     : one hex digit value
//   digit_idx_t  : index of the digit currently being scanned
//   slot_phase_t : BLANK (anodes forced off) or DRIVE (anode may be on)
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [3:0] nibble_t;
  typedef logic [1:0] digit_idx_t;

  typedef enum logic {
    SLOT_BLANK = 1'b0,
    SLOT_DRIVE = 1'b1
  } slot_phase_t;

endpackage

// File: rtl/seg7_refresh_ctr.sv
// Slot/digit timing for the 7-segment scanner.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   cnt_o           : slot cycle count for the upcoming cycle
//   idx_o           : digit index for the upcoming cycle
//   phase_o         : BLANK/DRIVE phase for the upcoming cycle
//   frame_wrap_o    : high when the coming edge moves idx from 3 back to 0
// The cnt/idx/phase outputs are next-state values so the parent can register
// its outputs from them and stay cycle-aligned with the counter.
module seg7_refresh_ctr
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 8,
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [CW-1:0] cnt_o,
  output digit_idx_t    idx_o,
  output slot_phase_t   phase_o,
  output logic          frame_wrap_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  digit_idx_t    idx_q, idx_d;
  // run_q is low only for the first edge after reset: that edge represents
  // cycle (cnt=0, idx=0) rather than advancing past it, so the first visible
  // cycle after reset release is the start of a frame.
  logic          run_q, run_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      run_q <= run_d;
    end
  end

  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    run_d        = 1'b1;
    frame_wrap_o = 1'b0;
    if (run_q) begin
      if (cnt_q == CW'(REFRESH_DIV - 1)) begin
        cnt_d        = '0;
        idx_d        = idx_q + 2'd1;
        frame_wrap_o = (idx_q == 2'd3);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign cnt_o = cnt_d;
  assign idx_o = idx_d;

  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign phase_o = SLOT_DRIVE;
    end else begin : g_blank
      assign phase_o = (cnt_d < CW'(BLANK_CYCLES)) ? SLOT_BLANK : SLOT_DRIVE;
    end
  endgenerate

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed scanner for a 4-digit common-anode 7-segment display.
// A frame-coherent snapshot of digits/dp/enables is taken when the scan wraps
// from digit 3 to digit 0; each digit then gets a fixed slot whose first
// BLANK_CYCLES cycles keep all anodes off to suppress ghosting.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   digits_i   : four nibbles, digit k at [4k+3:4k], digit 0 rightmost
//   dp_i       : decimal point per digit, 1 = lit
//   en_i       : digit enable, 1 = displayed
//   digit_o    : nibble of the active digit (to hex7seg)
//   an_o       : anode select, active low
//   dp_o       : decimal point, active low
//   frame_o    : one-cycle pulse on the first cycle of each frame
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits_i,
  input  logic [3:0]  dp_i,
  input  logic [3:0]  en_i,
  output logic [3:0]  digit_o,
  output logic [3:0]  an_o,
  output logic        dp_o,
  output logic        frame_o
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0] cnt_nxt;
  digit_idx_t    idx_nxt;
  slot_phase_t   phase_nxt;
  logic          frame_wrap;

  seg7_refresh_ctr #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_ctr (
    .clk          (clk),
    .rst_n        (rst_n),
    .cnt_o        (cnt_nxt),
    .idx_o        (idx_nxt),
    .phase_o      (phase_nxt),
    .frame_wrap_o (frame_wrap)
  );

  logic [15:0] dig_s_q, dig_s_d;
  logic [3:0]  dp_s_q,  dp_s_d;
  logic [3:0]  en_s_q,  en_s_d;
  nibble_t     digit_q, digit_d;
  logic [3:0]  an_q,    an_d;
  logic        dp_q,    dp_d;
  logic        frame_q, frame_d;
  logic        drive;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_s_q <= '0;
      dp_s_q  <= '0;
      en_s_q  <= '0;
      digit_q <= '0;
      an_q    <= 4'b1111;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      dig_s_q <= dig_s_d;
      dp_s_q  <= dp_s_d;
      en_s_q  <= en_s_d;
      digit_q <= digit_d;
      an_q    <= an_d;
      dp_q    <= dp_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    // Inputs only matter on the frame-wrap edge, so a frame never tears.
    dig_s_d = frame_wrap ? digits_i : dig_s_q;
    dp_s_d  = frame_wrap ? dp_i     : dp_s_q;
    en_s_d  = frame_wrap ? en_i     : en_s_q;

    // Output flops are fed from next-state values so they line up with the
    // counter cycle they describe. digit_o is valid during BLANK too, letting
    // the segment decoder settle before the anode switches on.
    digit_d = dig_s_d[{idx_nxt, 2'b00} +: 4];
    drive   = (phase_nxt == SLOT_DRIVE) && en_s_d[idx_nxt];
    an_d    = drive ? ~(4'b0001 << idx_nxt) : 4'b1111;
    dp_d    = drive ? ~dp_s_d[idx_nxt] : 1'b1;
    frame_d = (cnt_nxt == '0) && (idx_nxt == 2'd0);
  end

  assign digit_o = digit_q;
  assign an_o    = an_q;
  assign dp_o    = dp_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
module tb_seg7_scan_mux;

  localparam int RD = 4;
  localparam int BC = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits_i = '0;
  logic [3:0]  dp_i = '0;
  logic [3:0]  en_i = '0;

  logic [3:0]  digit_o, an_o, digit0_o, an0_o;
  logic        dp_o, frame_o, dp0_o, frame0_o;

  always #5 clk = ~clk;

  seg7_scan_mux #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) u_dut (
    .clk(clk), .rst_n(rst_n), .digits_i(digits_i), .dp_i(dp_i), .en_i(en_i),
    .digit_o(digit_o), .an_o(an_o), .dp_o(dp_o), .frame_o(frame_o)
  );

  // Same stimulus, no blanking phase.
  seg7_scan_mux #(.REFRESH_DIV(RD), .BLANK_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .digits_i(digits_i), .dp_i(dp_i), .en_i(en_i),
    .digit_o(digit0_o), .an_o(an0_o), .dp_o(dp0_o), .frame_o(frame0_o)
  );

  typedef struct {
    logic [3:0] digit;
    logic [3:0] an;
    logic [3:0] an0;
    logic       dp;
    logic       dp0;
    logic       frame;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: cycle number since reset release plus the frame snapshot.
  bit          started = 0;
  int          t = 0;
  logic [15:0] m_dig = '0;
  logic [3:0]  m_dp = '0;
  logic [3:0]  m_en = '0;

  function automatic exp_t model_expect(input bit in_reset);
    exp_t x;
    int   cnt, slot;
    x.digit = 4'h0; x.an = 4'hf; x.an0 = 4'hf;
    x.dp = 1'b1; x.dp0 = 1'b1; x.frame = 1'b0;
    if (!in_reset) begin
      cnt     = t % RD;
      slot    = (t / RD) % 4;
      x.digit = 4'((m_dig >> (4 * slot)) & 16'hf);
      x.frame = ((t % (4 * RD)) == 0);
      if (m_en[slot]) begin
        if (cnt >= BC) begin
          x.an = 4'(~(4'b0001 << slot));
          x.dp = ~m_dp[slot];
        end
        x.an0 = 4'(~(4'b0001 << slot));
        x.dp0 = ~m_dp[slot];
      end
    end
    return x;
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: push the expectation for the cycle just started, then
  // drive the inputs that will be present at the next edge.
  task automatic step(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e,
                      input bit rst_val, input bit try_rst, output bit hit);
    exp_t x;
    bit   r;
    hit = 1'b0;
    @(posedge clk);
    r = rst_n;
    #1;
    if (!r) begin
      started = 0;
      m_dig = '0; m_dp = '0; m_en = '0;
      x = model_expect(1'b1);
    end else begin
      if (!started) begin
        started = 1;
        t = 0;
      end else begin
        t++;
      end
      x = model_expect(1'b0);
    end
    digits_i = d; dp_i = p; en_i = e;
    rst_n = rst_val;
    if (try_rst && r && x.an == 4'b1011) begin
      check("pre_rst_an", an_o, 4'b1011);
      rst_n = 1'b0;
      #1;
      check("async_rst_an", an_o, 4'b1111);
      check("async_rst_an0", an0_o, 4'b1111);
      started = 0;
      m_dig = '0; m_dp = '0; m_en = '0;
      x = model_expect(1'b1);
      hit = 1'b1;
    end else if (r && (t % (4 * RD)) == (4 * RD - 1)) begin
      m_dig = d; m_dp = p; m_en = e;
    end
    sb_q.push_back(x);
    $display("cyc t=%0d rst=%0b exp an=%b digit=%h dp=%b frame=%b an0=%b",
             t, !r, x.an, x.digit, x.dp, x.frame, x.an0);
  endtask

  // Monitor: compare every cycle's outputs against the queued expectation.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        check("digit", digit_o, x.digit);
        check("an", an_o, x.an);
        check("dp", {3'b0, dp_o}, {3'b0, x.dp});
        check("frame", {3'b0, frame_o}, {3'b0, x.frame});
        check("an0", an0_o, x.an0);
        check("dp0", {3'b0, dp0_o}, {3'b0, x.dp0});
        check("frame0", {3'b0, frame0_o}, {3'b0, x.frame});
      end
    end
  end

  initial begin
    bit hit;
    bit found;
    // Reset held, then released.
    repeat (3) step(16'h0, 4'h0, 4'h0, 1'b0, 1'b0, hit);
    step(16'h1234, 4'h0, 4'hf, 1'b1, 1'b0, hit);
    // Frame 0 is dark; 1234 is captured at its end.
    repeat (16) step(16'h1234, 4'h0, 4'hf, 1'b1, 1'b0, hit);
    // Frame 1: change inputs during slot 1; display must not tear.
    repeat (6) step(16'h1234, 4'h0, 4'hf, 1'b1, 1'b0, hit);
    repeat (10) step(16'hABCD, 4'h0, 4'hf, 1'b1, 1'b0, hit);
    // Frame 2 shows ABCD; load enables/dp pattern for frame 3.
    repeat (16) step(16'hABCD, 4'b0100, 4'b0101, 1'b1, 1'b0, hit);
    repeat (16) step(16'h5678, 4'b0100, 4'b0101, 1'b1, 1'b0, hit);
    // Randomized frames.
    repeat (96) step(16'($urandom), 4'($urandom), 4'($urandom), 1'b1, 1'b0, hit);
    // All digits enabled, then assert reset asynchronously mid-DRIVE of slot 2.
    repeat (16) step(16'($urandom), 4'($urandom), 4'hf, 1'b1, 1'b0, hit);
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      step(16'($urandom), 4'($urandom), 4'hf, 1'b1, 1'b1, hit);
      found = hit;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL async_rst_window: got none expected an_o=1011 within 64 cycles");
    end
    repeat (2) step(16'h0, 4'h0, 4'hf, 1'b0, 1'b0, hit);
    step(16'($urandom), 4'($urandom), 4'hf, 1'b1, 1'b0, hit);
    // Dark frame again after release, then more random traffic.
    repeat (48) step(16'($urandom), 4'($urandom), 4'($urandom | 32'h8), 1'b1, 1'b0, hit);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
